// File: rtl/mem_if_pkg.sv
// Shared definitions for the mov/moc memory handshake, used by the
// initiator and by any responder on the same bus.
package mem_if_pkg;

    localparam logic [1:0] TYPE_BYTE    = 2'b00;
    localparam logic [1:0] TYPE_HALF    = 2'b01;
    localparam logic [1:0] TYPE_WORD    = 2'b10;
    localparam logic [1:0] TYPE_ILLEGAL = 2'b11;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TYPE     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    localparam logic RW_READ = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RESP    = 3'd4
    } state_e;

    // Right-justified write data masked to the access width.
    function automatic logic [31:0] fmt_write(input logic [31:0] wdata, input logic [1:0] acc);
        case (acc)
            TYPE_BYTE: fmt_write = {24'h0, wdata[7:0]};
            TYPE_HALF: fmt_write = {16'h0, wdata[15:0]};
            default:   fmt_write = wdata;
        endcase
    endfunction

    function automatic logic [31:0] extend_read(input logic [31:0] dout, input logic [1:0] acc,
                                                input logic sgn);
        case (acc)
            TYPE_BYTE: extend_read = {{24{sgn & dout[7]}}, dout[7:0]};
            TYPE_HALF: extend_read = {{16{sgn & dout[15]}}, dout[15:0]};
            default:   extend_read = dout;
        endcase
    endfunction

endpackage

// File: rtl/mem_initiator_moc_sync.sv
// Multi-flop synchronizer bringing the asynchronous moc strobe into clk.
module moc_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    if (SYNC_STAGES < 2) begin : g_depth_check
        $error("moc_sync needs at least two stages");
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/mem_initiator.sv
// Bus master for the mov/moc four-phase memory handshake: validates a core
// request, drives the responder, and returns extended read data with status.
module mem_initiator
    import mem_if_pkg::*;
#(
    parameter int TIMEOUT     = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [1:0]  req_type,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,
    output logic        mem_rw,
    output logic [1:0]  mem_type,
    output logic        mem_mov,
    input  logic        mem_moc
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic        rw_q;
    logic [1:0]  type_q;
    logic        signed_q;
    logic [31:0] cap_q;
    logic        req_ready_q, resp_valid_q, mem_rw_q, mem_mov_q;
    logic [31:0] resp_rdata_q, mem_addr_q, mem_din_q;
    logic [1:0]  resp_err_q, mem_type_q;
    logic        moc_s;
    logic [1:0]  chk_err_d;
    logic        wait_done_d;

    moc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_moc_sync (
        .clk_i (clk),
        .rst_i (reset),
        .d_i   (mem_moc),
        .q_o   (moc_s)
    );

    always_comb begin
        chk_err_d = ERR_OK;
        if (req_type == TYPE_ILLEGAL) begin
            chk_err_d = ERR_TYPE;
        end else if ((req_type == TYPE_HALF && req_addr[0]) ||
                     (req_type == TYPE_WORD && req_addr[1:0] != 2'b00)) begin
            chk_err_d = ERR_MISALIGN;
        end
    end

    // SETUP and RELEASE wait for moc low, STROBE waits for moc high.
    always_comb begin
        wait_done_d = 1'b0;
        case (state_q)
            ST_SETUP, ST_RELEASE: wait_done_d = ~moc_s;
            ST_STROBE:            wait_done_d = moc_s;
            default:              wait_done_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            rw_q         <= RW_READ;
            type_q       <= TYPE_BYTE;
            signed_q     <= 1'b0;
            cap_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= ERR_OK;
            mem_mov_q    <= 1'b0;
            mem_rw_q     <= RW_READ;
            mem_type_q   <= TYPE_BYTE;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        rw_q        <= req_rw;
                        type_q      <= req_type;
                        signed_q    <= req_signed;
                        cap_q       <= '0;
                        req_ready_q <= 1'b0;
                        if (chk_err_d != ERR_OK) begin
                            resp_err_q   <= chk_err_d;
                            resp_rdata_q <= '0;
                            resp_valid_q <= 1'b1;
                            state_q      <= ST_RESP;
                        end else begin
                            mem_addr_q <= req_addr;
                            mem_rw_q   <= req_rw;
                            mem_type_q <= req_type;
                            mem_din_q  <= fmt_write(req_wdata, req_type);
                            cnt_q      <= '0;
                            state_q    <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP, ST_STROBE, ST_RELEASE: begin
                    if (wait_done_d) begin
                        cnt_q <= '0;
                        if (state_q == ST_SETUP) begin
                            mem_mov_q <= 1'b1;
                            state_q   <= ST_STROBE;
                        end else if (state_q == ST_STROBE) begin
                            mem_mov_q <= 1'b0;
                            if (rw_q == RW_READ) begin
                                cap_q <= extend_read(mem_dout, type_q, signed_q);
                            end
                            state_q <= ST_RELEASE;
                        end else begin
                            resp_err_q   <= ERR_OK;
                            resp_rdata_q <= cap_q;
                            resp_valid_q <= 1'b1;
                            state_q      <= ST_RESP;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        // cap_q is still zero unless the timeout hit in RELEASE.
                        mem_mov_q    <= 1'b0;
                        resp_err_q   <= ERR_TIMEOUT;
                        resp_rdata_q <= cap_q;
                        resp_valid_q <= 1'b1;
                        state_q      <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RESP: begin
                    req_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    mem_mov_q   <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign mem_rw     = mem_rw_q;
    assign mem_type   = mem_type_q;
    assign mem_mov    = mem_mov_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Bench for mem_initiator with a behavioural 256x8 big-endian responder
// whose moc can follow mov, stick low, or stick high once raised.
module tb_mem_initiator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_rw = 1'b1;
    logic [1:0]  req_type = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        mem_rw;
    logic [1:0]  mem_type;
    logic        mem_mov;
    logic        mem_moc;

    int tests = 0;
    int fails = 0;

    mem_initiator #(.TIMEOUT(64), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rw     (req_rw),
        .req_type   (req_type),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .mem_rw     (mem_rw),
        .mem_type   (mem_type),
        .mem_mov    (mem_mov),
        .mem_moc    (mem_moc)
    );

    always #5 clk = ~clk;

    // Responder: 0 = moc follows mov, 1 = moc stuck low, 2 = moc sticks high after first mov.
    logic [1:0] moc_mode = 2'd0;
    int         stuck_cnt = 0;
    int         stuck_base = 0;
    logic [7:0] ram [256];
    logic [7:0] a0, a1, a2, a3;

    assign a0 = mem_addr[7:0];
    assign a1 = mem_addr[7:0] + 8'd1;
    assign a2 = mem_addr[7:0] + 8'd2;
    assign a3 = mem_addr[7:0] + 8'd3;

    assign mem_moc = (moc_mode == 2'd0) ? mem_mov :
                     (moc_mode == 2'd2) ? (mem_mov | (stuck_cnt != stuck_base)) : 1'b0;

    always @(posedge mem_mov) begin
        if (moc_mode != 2'd1 && mem_rw == 1'b0) begin
            case (mem_type)
                2'b00: ram[a0] <= mem_din[7:0];
                2'b01: begin ram[a0] <= mem_din[15:8]; ram[a1] <= mem_din[7:0]; end
                default: begin
                    ram[a0] <= mem_din[31:24]; ram[a1] <= mem_din[23:16];
                    ram[a2] <= mem_din[15:8];  ram[a3] <= mem_din[7:0];
                end
            endcase
        end
        if (moc_mode == 2'd2) stuck_cnt <= stuck_cnt + 1;
    end

    always_comb begin
        mem_dout = 32'h0;
        case (mem_type)
            2'b00:   mem_dout = {24'h0, ram[a0]};
            2'b01:   mem_dout = {16'h0, ram[a0], ram[a1]};
            default: mem_dout = {ram[a0], ram[a1], ram[a2], ram[a3]};
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Issues one request; lat counts edges from the accepting edge (1) to resp_valid.
    task automatic do_req(input logic rw, input logic [1:0] t, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic [1:0] er,
                          output int lat, output int mov_cyc);
        int guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1; req_rw = rw; req_type = t; req_signed = sg;
        req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        mov_cyc = mem_mov ? 1 : 0;
        while (!resp_valid && lat < 300) begin
            @(posedge clk); #1;
            lat++;
            if (mem_mov) mov_cyc++;
        end
        rd = resp_rdata;
        er = resp_err;
    endtask

    typedef struct {
        logic        rw;
        logic [1:0]  t;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [1:0]  exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs [20];

    initial begin
        logic [31:0] rd;
        logic [1:0]  er;
        int          lat, movc;
        bit          saw_resp;

        vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        2'b00, 8};
        vecs[1]  = '{1'b1, 2'b10, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 2'b00, 8};
        vecs[2]  = '{1'b0, 2'b10, 1'b0, 32'h20, 32'hA1A2A3A4, 32'h0,        2'b00, 8};
        vecs[3]  = '{1'b0, 2'b00, 1'b0, 32'h21, 32'h12345680, 32'h0,        2'b00, 8};
        vecs[4]  = '{1'b1, 2'b10, 1'b0, 32'h20, 32'h0,        32'hA180A3A4, 2'b00, 8};
        vecs[5]  = '{1'b1, 2'b00, 1'b1, 32'h21, 32'h0,        32'hFFFFFF80, 2'b00, 8};
        vecs[6]  = '{1'b1, 2'b00, 1'b0, 32'h21, 32'h0,        32'h00000080, 2'b00, 8};
        vecs[7]  = '{1'b1, 2'b01, 1'b1, 32'h10, 32'h0,        32'hFFFFDEAD, 2'b00, 8};
        vecs[8]  = '{1'b1, 2'b01, 1'b0, 32'h12, 32'h0,        32'h0000BEEF, 2'b00, 8};
        vecs[9]  = '{1'b1, 2'b10, 1'b1, 32'h10, 32'h0,        32'hDEADBEEF, 2'b00, 8};
        vecs[10] = '{1'b0, 2'b01, 1'b0, 32'h30, 32'hCAFE1234, 32'h0,        2'b00, 8};
        vecs[11] = '{1'b1, 2'b01, 1'b1, 32'h30, 32'h0,        32'h00001234, 2'b00, 8};
        vecs[12] = '{1'b0, 2'b10, 1'b0, 32'h50, 32'h11223344, 32'h0,        2'b00, 8};
        vecs[13] = '{1'b1, 2'b01, 1'b0, 32'h03, 32'h0,        32'h0,        2'b01, 1};
        vecs[14] = '{1'b1, 2'b10, 1'b0, 32'h12, 32'h0,        32'h0,        2'b01, 1};
        vecs[15] = '{1'b0, 2'b10, 1'b0, 32'h22, 32'h55555555, 32'h0,        2'b01, 1};
        vecs[16] = '{1'b1, 2'b11, 1'b0, 32'h00, 32'h0,        32'h0,        2'b10, 1};
        vecs[17] = '{1'b0, 2'b01, 1'b0, 32'h31, 32'h66666666, 32'h0,        2'b01, 1};
        vecs[18] = '{1'b0, 2'b11, 1'b0, 32'h31, 32'h77777777, 32'h0,        2'b10, 1};
        vecs[19] = '{1'b1, 2'b00, 1'b1, 32'h13, 32'h0,        32'hFFFFFFEF, 2'b00, 8};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready",  32'(req_ready),  32'h1);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_rdata", resp_rdata,      32'h0);
        check("rst_resp_err",   32'(resp_err),   32'h0);
        check("rst_mem_mov",    32'(mem_mov),    32'h0);
        check("rst_mem_rw",     32'(mem_rw),     32'h1);
        check("rst_mem_type",   32'(mem_type),   32'h0);
        check("rst_mem_addr",   mem_addr,        32'h0);
        check("rst_mem_din",    mem_din,         32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            do_req(vecs[i].rw, vecs[i].t, vecs[i].sg, vecs[i].addr, vecs[i].wdata, rd, er, lat, movc);
            check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_mov_cycles", i), 32'(movc), (vecs[i].exp_lat == 8) ? 32'd3 : 32'd0);
        end

        check("ram_10", 32'(ram[8'h10]), 32'hDE);
        check("ram_11", 32'(ram[8'h11]), 32'hAD);
        check("ram_12", 32'(ram[8'h12]), 32'hBE);
        check("ram_13", 32'(ram[8'h13]), 32'hEF);
        check("ram_21", 32'(ram[8'h21]), 32'h80);
        check("ram_22_untouched", 32'(ram[8'h22]), 32'hA3);
        check("ram_31_untouched", 32'(ram[8'h31]), 32'h34);

        // moc stuck low: STROBE holds mov for the full timeout window
        moc_mode = 2'd1;
        do_req(1'b1, 2'b10, 1'b0, 32'h40, 32'h0, rd, er, lat, movc);
        check("lowto_err", 32'(er), 32'h3);
        check("lowto_rdata", rd, 32'h0);
        check("lowto_latency", 32'(lat), 32'd66);
        check("lowto_mov_cycles", 32'(movc), 32'd64);
        check("lowto_mov_at_resp", 32'(mem_mov), 32'h0);
        @(posedge clk); #1;
        check("lowto_ready_after", 32'(req_ready), 32'h1);

        // moc sticks high: RELEASE timeout keeps data, then SETUP timeout with no strobe
        stuck_base = stuck_cnt;
        moc_mode = 2'd2;
        do_req(1'b1, 2'b10, 1'b0, 32'h50, 32'h0, rd, er, lat, movc);
        check("hito1_err", 32'(er), 32'h3);
        check("hito1_rdata", rd, 32'h11223344);
        check("hito1_latency", 32'(lat), 32'd69);
        check("hito1_mov_cycles", 32'(movc), 32'd3);
        do_req(1'b1, 2'b10, 1'b0, 32'h50, 32'h0, rd, er, lat, movc);
        check("hito2_err", 32'(er), 32'h3);
        check("hito2_rdata", rd, 32'h0);
        check("hito2_latency", 32'(lat), 32'd65);
        check("hito2_mov_cycles", 32'(movc), 32'd0);

        // Reset during STROBE
        moc_mode = 2'd0;
        repeat (4) @(negedge clk);
        req_valid = 1'b1; req_rw = 1'b1; req_type = 2'b10; req_signed = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("rstmid_mov_before", 32'(mem_mov), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("rstmid_mov_immediate", 32'(mem_mov), 32'h0);
        saw_resp = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (resp_valid) saw_resp = 1'b1;
        end
        check("rstmid_no_resp", 32'(saw_resp), 32'h0);
        check("rstmid_ready", 32'(req_ready), 32'h1);
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat, movc);
        check("rstmid_next_rdata", rd, 32'hDEADBEEF);
        check("rstmid_next_err", 32'(er), 32'h0);
        check("rstmid_next_latency", 32'(lat), 32'd8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
